// File: rtl/axis_lat_mon.sv
// axis_lat_mon
//   Passive per-packet latency monitor for an AXI4-Stream loopback path.
//   Every TX end-of-packet is timestamped from a free-running 64-bit cycle
//   counter and queued. The next RX end-of-packet is paired with the oldest
//   queued timestamp, in order. The resulting latency updates count, sum,
//   min, max and last. A host reads the stats through a snapshot register set.
//
//   Optional feature: define AXIS_LAT_MON_HIST_EN to build an N_BINS latency
//   histogram. When it is undefined there are no bin registers and snap_hist
//   reads as zero.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   tx_mon_t{valid,ready,last}  TX tap (observed only, never driven)
//   rx_mon_t{valid,ready,last}  RX tap (observed only, never driven)
//   snap                  pulse: copy the live stats to the snap_* outputs
//   clr                   pulse: clear the live stats, timestamp FIFO and flags
//   snap_pkt_cnt/lat_sum  snapshot packet count and latency sum (64 bit)
//   snap_lat_min/max      snapshot min/max latency
//   lat_last              most recent latency (live)
//   inflight              timestamps currently queued (live)
//   overflow/underflow    sticky pairing-lost flags (live)
//   snap_hist             snapshot histogram, bin i at [32*i +: 32]

module axis_lat_mon #(
  parameter int HAS_READY  = 0,
  parameter int HAS_LAST   = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int LAT_WIDTH  = 32,
  parameter int N_BINS     = 8,
  parameter int BIN_SHIFT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_mon_tvalid,
  input  logic                          tx_mon_tready,
  input  logic                          tx_mon_tlast,
  input  logic                          rx_mon_tvalid,
  input  logic                          rx_mon_tready,
  input  logic                          rx_mon_tlast,
  input  logic                          snap,
  input  logic                          clr,
  output logic [63:0]                   snap_pkt_cnt,
  output logic [63:0]                   snap_lat_sum,
  output logic [LAT_WIDTH-1:0]          snap_lat_min,
  output logic [LAT_WIDTH-1:0]          snap_lat_max,
  output logic [LAT_WIDTH-1:0]          lat_last,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic                          overflow,
  output logic                          underflow,
  output logic [N_BINS*32-1:0]          snap_hist
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Largest representable latency; shifting by 64 yields 0, so this is all-ones for LAT_WIDTH=64.
  localparam logic [63:0] LAT_MAX = (64'd1 << LAT_WIDTH) - 64'd1;

  logic tx_rdy, tx_lst, rx_rdy, rx_lst;
  logic tx_eop, rx_eop;

  // Disabled handshake signals are forced to 1 so every beat/transfer counts.
  assign tx_rdy = (HAS_READY != 0) ? tx_mon_tready : 1'b1;
  assign rx_rdy = (HAS_READY != 0) ? rx_mon_tready : 1'b1;
  assign tx_lst = (HAS_LAST  != 0) ? tx_mon_tlast  : 1'b1;
  assign rx_lst = (HAS_LAST  != 0) ? rx_mon_tlast  : 1'b1;
  assign tx_eop = tx_mon_tvalid & tx_rdy & tx_lst;
  assign rx_eop = rx_mon_tvalid & rx_rdy & rx_lst;

  logic [63:0]          time_cnt;
  logic [63:0]          ts_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop, bypass, ovf_evt, unf_evt, meas;
  logic [63:0]          lat_diff;
  logic [LAT_WIDTH-1:0] lat_meas;

  // Pairing decision. An EOP arriving on both sides while the FIFO is empty
  // pairs directly with zero latency. When the FIFO is full, a simultaneous
  // pop makes room for the push.
  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    bypass     = tx_eop & rx_eop & fifo_empty;
    pop        = rx_eop & ~fifo_empty;
    push       = tx_eop & ~bypass & (~fifo_full | rx_eop);
    ovf_evt    = tx_eop & ~rx_eop & fifo_full;
    unf_evt    = rx_eop & ~tx_eop & fifo_empty;
    meas       = pop | bypass;
    lat_diff   = time_cnt - ts_mem[rd_ptr];
    if (bypass) begin
      lat_meas = '0;
    end else if (lat_diff > LAT_MAX) begin
      lat_meas = '1;
    end else begin
      lat_meas = lat_diff[LAT_WIDTH-1:0];
    end
  end

  // Timestamp storage has no reset. Only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      ts_mem[wr_ptr] <= time_cnt;
    end
  end

  logic                 upd_pend;
  logic [LAT_WIDTH-1:0] upd_lat;

  // Time base, FIFO pointers and sticky flags. A measured latency is staged
  // for one cycle in upd_pend/upd_lat before it reaches the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      upd_pend  <= 1'b0;
      upd_lat   <= '0;
    end else begin
      time_cnt <= time_cnt + 64'd1;
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fifo_cnt  <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        upd_pend  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        if (ovf_evt) overflow  <= 1'b1;
        if (unf_evt) underflow <= 1'b1;
        upd_pend <= meas;
        if (meas) upd_lat <= lat_meas;
      end
    end
  end

  assign inflight = fifo_cnt;

  logic                 apply;
  logic [63:0]          pkt_cnt, lat_sum, pkt_cnt_nx, lat_sum_nx;
  logic [LAT_WIDTH-1:0] lat_min, lat_max, lat_min_nx, lat_max_nx, lat_last_nx;

  // Next-state stats before any clear. The snapshot samples these values, so
  // an update landing in the snap cycle is included, and snap+clr captures
  // the pre-clear values. Once pairing is lost, updates are ignored.
  always_comb begin
    apply       = upd_pend & ~overflow & ~underflow;
    pkt_cnt_nx  = pkt_cnt;
    lat_sum_nx  = lat_sum;
    lat_min_nx  = lat_min;
    lat_max_nx  = lat_max;
    lat_last_nx = lat_last;
    if (apply) begin
      pkt_cnt_nx  = pkt_cnt + 64'd1;
      lat_sum_nx  = lat_sum + 64'(upd_lat);
      lat_min_nx  = (upd_lat < lat_min) ? upd_lat : lat_min;
      lat_max_nx  = (upd_lat > lat_max) ? upd_lat : lat_max;
      lat_last_nx = upd_lat;
    end
  end

  // Live stats and their snapshot copies. clr leaves the snapshot untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt      <= '0;
      lat_sum      <= '0;
      lat_min      <= '1;
      lat_max      <= '0;
      lat_last     <= '0;
      snap_pkt_cnt <= '0;
      snap_lat_sum <= '0;
      snap_lat_min <= '1;
      snap_lat_max <= '0;
    end else begin
      if (clr) begin
        pkt_cnt  <= '0;
        lat_sum  <= '0;
        lat_min  <= '1;
        lat_max  <= '0;
        lat_last <= '0;
      end else begin
        pkt_cnt  <= pkt_cnt_nx;
        lat_sum  <= lat_sum_nx;
        lat_min  <= lat_min_nx;
        lat_max  <= lat_max_nx;
        lat_last <= lat_last_nx;
      end
      if (snap) begin
        snap_pkt_cnt <= pkt_cnt_nx;
        snap_lat_sum <= lat_sum_nx;
        snap_lat_min <= lat_min_nx;
        snap_lat_max <= lat_max_nx;
      end
    end
  end

`ifdef AXIS_LAT_MON_HIST_EN
  localparam int BW = $clog2(N_BINS);

  logic [31:0]          hist    [N_BINS];
  logic [31:0]          hist_nx [N_BINS];
  logic [LAT_WIDTH-1:0] lat_shr;
  logic [BW-1:0]        bin;

  // Latencies at or past the last bin boundary are folded into the top bin.
  // Bin counters saturate instead of wrapping.
  always_comb begin
    lat_shr = upd_lat >> BIN_SHIFT;
    bin     = (lat_shr >= LAT_WIDTH'(N_BINS - 1)) ? BW'(N_BINS - 1) : lat_shr[BW-1:0];
    for (int i = 0; i < N_BINS; i++) begin
      hist_nx[i] = hist[i];
      if (apply && (bin == BW'(i)) && (hist[i] != '1)) begin
        hist_nx[i] = hist[i] + 32'd1;
      end
    end
  end

  // Histogram follows the same clear/snapshot rules as the other stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BINS; i++) hist[i] <= '0;
      snap_hist <= '0;
    end else begin
      for (int i = 0; i < N_BINS; i++) begin
        hist[i] <= clr ? 32'd0 : hist_nx[i];
      end
      if (snap) begin
        for (int i = 0; i < N_BINS; i++) snap_hist[32*i +: 32] <= hist_nx[i];
      end
    end
  end
`else
  assign snap_hist = '0;
`endif

endmodule
